// File: rtl/xmm_scoreboard_regfile.sv
// ---------------------------------------------------------------------------
// xmm_scoreboard_regfile
//
// Multi-ported fixed-point (q15.48 by default) register file. It has a
// per-register busy scoreboard that tracks results still outstanding from the
// multi-cycle fixed-point unit.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   rd_addr/rd_data   NUM_RD packed combinational read ports (write-bypassed)
//   rd_busy           per-read-port busy bit, consistent with the bypass
//   wr0_*             single-cycle ALU writeback (loses collisions to wr1)
//   wr1_*             multi-cycle unit writeback; also clears busy
//   issue_en/addr     reserve a destination register (sets busy)
//   issue_ready       combinational: target of issue_addr is not busy
//   busy_count        number of busy registers
//   issue_err         sticky: an issue targeted an already-busy register
//
// Build option:
//   XMM_RF_ZERO_REG_EN  when defined, register 0 is hardwired to zero. Writes
//                       to it are dropped, and issues to it neither set busy
//                       nor raise issue_err.
// ---------------------------------------------------------------------------
module xmm_scoreboard_regfile #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_RD*ADDR_W-1:0]  rd_addr,
  output logic [NUM_RD*DATA_W-1:0]  rd_data,
  output logic [NUM_RD-1:0]         rd_busy,
  input  logic                      wr0_en,
  input  logic [ADDR_W-1:0]         wr0_addr,
  input  logic [DATA_W-1:0]         wr0_data,
  input  logic                      wr1_en,
  input  logic [ADDR_W-1:0]         wr1_addr,
  input  logic [DATA_W-1:0]         wr1_data,
  input  logic                      issue_en,
  input  logic [ADDR_W-1:0]         issue_addr,
  output logic                      issue_ready,
  output logic [ADDR_W:0]           busy_count,
  output logic                      issue_err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

`ifdef XMM_RF_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  // True when the address is the hardwired-zero register in this build
  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  // State
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  busy_q,       busy_d;
  logic [CNT_W-1:0]  busy_count_q, busy_count_d;
  logic              issue_err_q,  issue_err_d;

  // Qualified write strobes (zero register swallows writes)
  logic wr0_ok;
  logic wr1_ok;

  assign wr0_ok = wr0_en && !is_zero_reg(wr0_addr);
  assign wr1_ok = wr1_en && !is_zero_reg(wr1_addr);

  // Storage next state; wr1 is applied last so it wins a same-address collision
  always_comb begin
    mem_d = mem_q;
    if (wr0_ok) mem_d[wr0_addr] = wr0_data;
    if (wr1_ok) mem_d[wr1_addr] = wr1_data;
  end

  // Scoreboard next state: the wr1 clear is applied before the issue check,
  // so an issue racing a writeback to the same register is legal
  logic [DEPTH-1:0] busy_clr;
  logic             issue_tgt_busy;
  logic             issue_ok;
  logic             issue_bad;
  logic             clr_hit;

  always_comb begin
    busy_clr = busy_q;
    if (wr1_en) busy_clr[wr1_addr] = 1'b0;

    clr_hit        = wr1_en && busy_q[wr1_addr];
    issue_tgt_busy = busy_clr[issue_addr];
    issue_ok       = issue_en && !is_zero_reg(issue_addr) && !issue_tgt_busy;
    issue_bad      = issue_en && !is_zero_reg(issue_addr) &&  issue_tgt_busy;

    busy_d = busy_clr;
    if (issue_ok) busy_d[issue_addr] = 1'b1;

    // Incremental count; a set never targets a busy bit, so no overflow
    busy_count_d = busy_count_q + CNT_W'(issue_ok) - CNT_W'(clr_hit);
    issue_err_d  = issue_err_q | issue_bad;
  end

  // State registers; reset discards every write and issue of that cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q        <= '{default: '0};
      busy_q       <= '0;
      busy_count_q <= '0;
      issue_err_q  <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
      issue_err_q  <= issue_err_d;
    end
  end

  // Combinational read ports with write bypass (wr1 over wr0 over storage)
  logic [ADDR_W-1:0] ra;
  logic [DATA_W-1:0] rv;
  logic              rb;

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    rv      = '0;
    rb      = 1'b0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      ra = rd_addr[k*ADDR_W +: ADDR_W];
      rv = mem_q[ra];
      if (wr0_en && (wr0_addr == ra)) rv = wr0_data;
      if (wr1_en && (wr1_addr == ra)) rv = wr1_data;
      if (is_zero_reg(ra)) rv = '0;
      // A pending writeback hides busy so the bit matches the bypassed data
      rb = busy_q[ra] && !(wr1_en && (wr1_addr == ra));
      rd_data[k*DATA_W +: DATA_W] = rv;
      rd_busy[k]                  = rb;
    end
  end

  assign issue_ready = is_zero_reg(issue_addr) || !busy_q[issue_addr];
  assign busy_count  = busy_count_q;
  assign issue_err   = issue_err_q;

endmodule

// File: tb/tb_xmm_scoreboard_regfile.sv
// ---------------------------------------------------------------------------
// tb_xmm_scoreboard_regfile
//
// Directed bench for xmm_scoreboard_regfile (default parameters). A
// behavioural register-file/scoreboard model is checked against every DUT
// output on each negative clock edge. Hand-computed literal checks pin the
// scenarios from the test plan. It follows XMM_RF_ZERO_REG_EN like the DUT.
// ---------------------------------------------------------------------------
module tb_xmm_scoreboard_regfile;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 3;
  localparam int DEPTH  = 32;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr0_en;
  logic [ADDR_W-1:0]        wr0_addr;
  logic [DATA_W-1:0]        wr0_data;
  logic                     wr1_en;
  logic [ADDR_W-1:0]        wr1_addr;
  logic [DATA_W-1:0]        wr1_data;
  logic                     issue_en;
  logic [ADDR_W-1:0]        issue_addr;
  logic                     issue_ready;
  logic [ADDR_W:0]          busy_count;
  logic                     issue_err;

  xmm_scoreboard_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
    .clk        (clk),
    .reset      (reset),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .wr0_en     (wr0_en),
    .wr0_addr   (wr0_addr),
    .wr0_data   (wr0_data),
    .wr1_en     (wr1_en),
    .wr1_addr   (wr1_addr),
    .wr1_data   (wr1_data),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .issue_ready(issue_ready),
    .busy_count (busy_count),
    .issue_err  (issue_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

`ifdef XMM_RF_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  // Model state: register contents, busy set, sticky error
  logic [DATA_W-1:0] m_mem  [DEPTH];
  bit                m_busy [DEPTH];
  bit                m_err;

  function automatic bit zaddr(input logic [ADDR_W-1:0] a);
    return ZR && (a == 0);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] rdd(input int k);
    return rd_data[k*DATA_W +: DATA_W];
  endfunction

  function automatic logic [ADDR_W-1:0] rda(input int k);
    return rd_addr[k*ADDR_W +: ADDR_W];
  endfunction

  // Model update at the clock edge
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i]  = '0;
        m_busy[i] = 1'b0;
      end
      m_err = 1'b0;
    end else begin
      if (wr0_en && !zaddr(wr0_addr)) m_mem[wr0_addr] = wr0_data;
      if (wr1_en && !zaddr(wr1_addr)) m_mem[wr1_addr] = wr1_data;
      if (wr1_en) m_busy[wr1_addr] = 1'b0;
      if (issue_en && !zaddr(issue_addr)) begin
        if (m_busy[issue_addr]) m_err = 1'b1;
        else                    m_busy[issue_addr] = 1'b1;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < NUM_RD; k++) begin
        automatic logic [ADDR_W-1:0] a = rda(k);
        automatic logic [DATA_W-1:0] ed = m_mem[a];
        automatic bit eb;
        if (wr0_en && wr0_addr == a) ed = wr0_data;
        if (wr1_en && wr1_addr == a) ed = wr1_data;
        if (zaddr(a)) ed = '0;
        eb = m_busy[a] && !(wr1_en && wr1_addr == a);
        chk($sformatf("model rd_data[%0d]", k), rdd(k), ed);
        chk($sformatf("model rd_busy[%0d]", k), 64'(rd_busy[k]), 64'(eb));
      end
      begin
        automatic int cnt = 0;
        for (int i = 0; i < DEPTH; i++) cnt += int'(m_busy[i]);
        chk("model busy_count", 64'(busy_count), 64'(cnt));
      end
      chk("model issue_ready", 64'(issue_ready), 64'(zaddr(issue_addr) || !m_busy[issue_addr]));
      chk("model issue_err", 64'(issue_err), 64'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int a0, input int a1, input int a2);
    rd_addr = {5'(a2), 5'(a1), 5'(a0)};
  endtask

  task automatic idle();
    wr0_en = 1'b0; wr1_en = 1'b0; issue_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rd_addr = '0;
    wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
    wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
    issue_en = 1'b0; issue_addr = '0;
    for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_busy[i] = 1'b0; end
    m_err = 1'b0;
    tick();
    started = 1'b1;
    tick();
    reset = 1'b0;

    // 1: post-reset state on every address
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(a, a, a);
      issue_addr = 5'(a);
      #2;
      chk("reset rd_data", rdd(0), 64'h0);
      chk("reset rd_busy", 64'(rd_busy), 64'h0);
      chk("reset issue_ready", 64'(issue_ready), 64'h1);
      tick();
    end
    chk("reset busy_count", 64'(busy_count), 64'h0);
    chk("reset issue_err", 64'(issue_err), 64'h0);

    // 2: wr0 bypass then storage; wr0/wr1 collision
    set_rd(5, 7, 0);
    wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 64'h0001_0000_0000_0000;
    #2 chk("bypass wr0 addr5", rdd(0), 64'h0001_0000_0000_0000);
    tick(); idle();
    #2 chk("stored addr5", rdd(0), 64'h0001_0000_0000_0000);
    wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 64'h11;
    wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 64'h22;
    #2 chk("collision bypass addr7", rdd(1), 64'h22);
    tick(); idle();
    #2 chk("collision stored addr7", rdd(1), 64'h22);

    // 3: issue, duplicate issue, writeback
    set_rd(0, 0, 9);
    issue_en = 1'b1; issue_addr = 5'd9;
    tick(); idle();
    #2;
    chk("issue9 busy_count", 64'(busy_count), 64'h1);
    chk("issue9 rd_busy", 64'(rd_busy[2]), 64'h1);
    chk("issue9 issue_ready", 64'(issue_ready), 64'h0);
    issue_en = 1'b1;
    tick(); idle();
    #2;
    chk("dup issue9 err", 64'(issue_err), 64'h1);
    chk("dup issue9 count", 64'(busy_count), 64'h1);
    wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 64'h33;
    #2;
    chk("wb9 bypass rd_busy", 64'(rd_busy[2]), 64'h0);
    chk("wb9 bypass rd_data", rdd(2), 64'h33);
    tick(); idle();
    #2;
    chk("wb9 busy_count", 64'(busy_count), 64'h0);
    chk("wb9 err sticky", 64'(issue_err), 64'h1);

    // 4: same-cycle clear and re-issue of register 3
    reset = 1'b1; tick(); reset = 1'b0;
    set_rd(3, 0, 0);
    issue_en = 1'b1; issue_addr = 5'd3;
    tick(); idle();
    wr1_en = 1'b1; wr1_addr = 5'd3; wr1_data = 64'h44;
    issue_en = 1'b1; issue_addr = 5'd3;
    tick(); idle();
    #2;
    chk("reissue3 rd_busy", 64'(rd_busy[0]), 64'h1);
    chk("reissue3 count", 64'(busy_count), 64'h1);
    chk("reissue3 err", 64'(issue_err), 64'h0);
    chk("reissue3 data", rdd(0), 64'h44);

    // 5: back-to-back issues then reset with traffic in flight
    for (int i = 0; i < 10; i++) begin
      issue_en = 1'b1; issue_addr = 5'(10 + i);
      tick();
    end
    #2 chk("ten issues count", 64'(busy_count), 64'd11);
    issue_addr = 5'd20;
    wr0_en = 1'b1; wr0_addr = 5'd21; wr0_data = 64'h55;
    reset = 1'b1;
    tick(); idle(); reset = 1'b0;
    set_rd(3, 21, 20);
    #2;
    chk("mid reset count", 64'(busy_count), 64'h0);
    chk("mid reset addr3", rdd(0), 64'h0);
    chk("mid reset addr21", rdd(1), 64'h0);
    chk("mid reset rd_busy", 64'(rd_busy), 64'h0);
    chk("mid reset err", 64'(issue_err), 64'h0);

    // 6: register 0 behaviour
    set_rd(0, 0, 0);
    wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 64'hFF;
    tick(); idle();
    issue_en = 1'b1; issue_addr = 5'd0;
    tick(); tick(); idle();
    #2;
`ifdef XMM_RF_ZERO_REG_EN
    chk("zero reg data", rdd(0), 64'h0);
    chk("zero reg count", 64'(busy_count), 64'h0);
    chk("zero reg err", 64'(issue_err), 64'h0);
`else
    chk("reg0 data", rdd(0), 64'hFF);
    chk("reg0 count", 64'(busy_count), 64'h1);
    chk("reg0 err", 64'(issue_err), 64'h1);
`endif

    // Mixed traffic over a small address window, checked by the model
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 80; i++) begin
      set_rd($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      wr0_en = 1'($urandom_range(0, 1)); wr0_addr = 5'($urandom_range(0, 7));
      wr0_data = {$urandom, $urandom};
      wr1_en = 1'($urandom_range(0, 1)); wr1_addr = 5'($urandom_range(0, 7));
      wr1_data = {$urandom, $urandom};
      issue_en = 1'($urandom_range(0, 1)); issue_addr = 5'($urandom_range(0, 7));
      tick();
    end
    idle();
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xmm_scoreboard_regfile.md
Name: xmm_scoreboard_regfile

Overview:
Parametrised successor to the q15.48 XMM register file. Adds:
- NUM_RD combinational read ports.
- Two write ports: the single-cycle ALU writeback and the multi-cycle fixed-point unit writeback.
- Write-to-read bypass.
- Per-register busy scoreboard, so issue logic can stall on registers with an outstanding multi-cycle result.

It sits between decode/issue and the fixed-point execution units.

Parameters:
- DATA_W, 64: register width in bits (q15.48 at default).
- ADDR_W, 5: address width; DEPTH = 2**ADDR_W registers.
- NUM_RD, 3: number of read ports (>=1).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous active-high reset.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k is bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed read data, bypassed.
- rd_busy  out  NUM_RD  busy bit per read port, bypassed.
- wr0_en  in  1  ALU write enable.
- wr0_addr  in  ADDR_W  ALU write address.
- wr0_data  in  DATA_W  ALU write data.
- wr1_en  in  1  multi-cycle unit writeback enable; also clears busy.
- wr1_addr  in  ADDR_W  writeback address.
- wr1_data  in  DATA_W  writeback data.
- issue_en  in  1  reserve destination for a multi-cycle op.
- issue_addr  in  ADDR_W  destination to mark busy.
- issue_ready  out  1  combinational; high when busy[issue_addr]==0.
- busy_count  out  ADDR_W+1  number of busy registers.
- issue_err  out  1  sticky flag: issue attempted while the target was busy.

Behaviour:
- Reset, sampled at posedge: clears the following, and discards all writes/issues in that cycle.
  - All registers = 0.
  - busy = 0, busy_count = 0, issue_err = 0.
  - After reset: rd_data = 0 for every address; issue_ready = 1.
- Writes commit at posedge, 1-cycle latency.
- Write collision (wr0 and wr1 to the same address in the same cycle): wr1 wins; wr0 is dropped.
- Reads are combinational with bypass:
  - rd_data[k] = wr1_data if wr1_en && wr1_addr==rd_addr[k].
  - Else wr0_data if wr0_en && wr0_addr==rd_addr[k].
  - Else the stored value.
  - A value written at edge N is visible on the read port in the same cycle before edge N (bypass) and from storage after edge N.
- Busy scoreboard, DEPTH bits, updated at posedge:
  - issue_en && !busy[issue_addr]: set busy[issue_addr].
  - issue_en && busy[issue_addr]: request ignored, busy unchanged, issue_err <= 1 (sticky until reset).
  - wr1_en: clear busy[wr1_addr].
  - Same-cycle wr1 clear and issue to the same address: the clear is evaluated first, so the issue is legal and busy ends set. The wr1 data still commits. Net busy_count change is 0.
  - wr0 does not touch busy. A wr0 write to a busy register is a legal overwrite and is later overwritten by wr1.
- rd_busy[k] = busy[rd_addr[k]] && !(wr1_en && wr1_addr==rd_addr[k]). This keeps rd_busy consistent with the bypassed data.
- busy_count is maintained incrementally:
  - +1 on a successful set.
  - -1 on a clear of a set bit.
  - Clearing a non-busy register: no change, no error.
  - Range 0..DEPTH; it cannot overflow because a set requires busy==0.

Optional Feature:
XMM_RF_ZERO_REG_EN.
- Defined:
  - Register 0 reads as 0, including bypass (writes to address 0 are ignored on both ports).
  - Issue to address 0 never sets busy and never raises issue_err.
  - rd_busy for address 0 is always 0; issue_ready is 1 when issue_addr==0.
- Undefined: register 0 is an ordinary register.

Test Plan:
1. Reset, then read all 32 addresses on all ports -> rd_data=0, rd_busy=0, busy_count=0, issue_ready=1, issue_err=0.
2. wr0 addr 5 = 0x0001_0000_0000_0000, with rd_addr[0]=5 in the same cycle -> rd_data[0] already equals the value before the edge, and it is held after the edge. Simultaneous wr0 and wr1 to addr 7 with 0x11 / 0x22 -> addr 7 reads 0x22.
3. Issue addr 9 -> busy_count=1, rd_busy for 9 =1, issue_ready(9)=0. A second issue to 9 is ignored and issue_err=1. Then wr1 addr 9 = 0x33 -> in the same cycle rd_busy=0 and rd_data=0x33; after the edge busy_count=0 and issue_err stays 1.
4. Busy on 3; same cycle wr1 addr 3 and issue addr 3 -> busy[3] remains 1, busy_count unchanged, no issue_err, data = wr1 value.
5. Issue 10 registers back-to-back, then reset asserted mid-stream with issue_en and wr0_en high -> after the edge everything is 0, no writes committed, busy_count=0.
6. With XMM_RF_ZERO_REG_EN: wr0 addr 0 = 0xFF and issue addr 0 twice -> reads 0, busy_count=0, issue_err=0. Without the macro: addr 0 reads 0xFF and issue_err=1.
